// File: rtl/alu_issue_stage.sv
// Issue stage feeding a multi-cycle RV32I ALU: decodes one instruction, reads the
// register file, strobes the ALU, waits its latency and writes the result back.
module alu_issue_stage #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int ALU_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic            enable,
  input  logic [XLEN-1:0] result,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [1:0]      r_state;
  logic [2:0]      r_cnt;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic            r_enable;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_illegal;

  // x0 has no storage; reads of index 0 are forced to zero below.
  logic [XLEN-1:0] r_regs [1:NREGS-1];

  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic            w_supported;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;

  assign w_rs1     = in_instr[19:15];
  assign w_rs2     = in_instr[24:20];
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
  assign w_imm_i   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign w_imm_u   = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};

  always_comb begin
    w_supported = 1'b1;
    w_op1       = '0;
    w_op2       = '0;
    case (in_instr[6:0])
      OPC_OP: begin
        w_op1 = w_rs1_val;
        w_op2 = w_rs2_val;
      end
      OPC_OP_IMM: begin
        w_op1 = w_rs1_val;
        w_op2 = w_imm_i;
      end
      OPC_LUI:   w_op1 = w_imm_u;
      OPC_AUIPC: w_op1 = in_pc + w_imm_u;
      default:   w_supported = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_instr    <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_enable   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_enable   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_supported) begin
              r_instr  <= in_instr;
              r_op1    <= w_op1;
              r_op2    <= w_op2;
              r_enable <= 1'b1;
              r_state  <= S_ISSUE;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= 3'(ALU_LATENCY);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The decrement that would reach zero is the edge the ALU result is valid.
          if (r_cnt == 3'd1) begin
            r_wb_data  <= result;
            r_wb_rd    <= r_instr[11:7];
            r_wb_valid <= 1'b1;
            r_state    <= S_WB;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_regs
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_regs[gi] <= '0;
        end else if (r_state == S_WB && r_wb_rd == 5'(gi)) begin
          r_regs[gi] <= r_wb_data;
        end
      end
    end
  endgenerate

  assign in_ready = (r_state == S_IDLE);
  assign instr    = r_instr;
  assign op1      = r_op1;
  assign op2      = r_op2;
  assign enable   = r_enable;
  assign wb_valid = r_wb_valid;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign illegal  = r_illegal;
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];

endmodule
